// File: rtl/tfe_result_buffer_if.sv
// Result stream between the TensorFlowE core and the output path.
// Producer side pushes bytes; consumer side drains via valid/ready.
interface tfe_result_buffer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] datos_in;
  logic              ena_in;
  logic              relu_on;
  logic [DATA_W-1:0] datos_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output datos_in,
    output ena_in,
    output relu_on,
    output ready_in,
    input  datos_out,
    input  valid_out
  );

  modport slave (
    input  datos_in,
    input  ena_in,
    input  relu_on,
    input  ready_in,
    output datos_out,
    output valid_out
  );
endinterface

// File: rtl/tfe_result_buffer.sv
// Result capture FIFO after the TensorFlowE core.
// Optional ReLU on push, show-ahead head, drop tracking.
module tfe_result_buffer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tfe_result_buffer_if.slave         bus,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              ovf;
  logic [7:0]        drops;

  logic              valid;
  logic              push;
  logic              pop;
  logic              drop;
  logic              relu_hit;
  logic [DATA_W-1:0] wr_data;

  assign valid = (cnt != '0);
  assign full  = (cnt == CNT_MAX);
  assign pop   = valid & bus.ready_in;
  assign push  = bus.ena_in & (~full | pop);
  assign drop  = bus.ena_in & full & ~pop;

  assign relu_hit = RELU_EN & bus.relu_on
                  & bus.datos_in[DATA_W-1];
  assign wr_data  = relu_hit ? '0 : bus.datos_in;

  assign bus.valid_out = valid;
  assign bus.datos_out = valid ? mem[rd_ptr] : '0;
  assign count         = cnt;
  assign overflow      = ovf;
  assign drop_cnt      = drops;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and drop bookkeeping; clear beats push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drops != 8'hFF) begin
          drops <= drops + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tfe_result_buffer.sv
// Directed bench for tfe_result_buffer.
// Hand-computed expectations, immediate assertions.
module tb_tfe_result_buffer;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks;
  int errors;

  tfe_result_buffer_if #(.DATA_W(8)) bus ();

  tfe_result_buffer #(
    .DATA_W (8),
    .DEPTH  (8),
    .RELU_EN(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clear   (clear),
    .count   (count),
    .full    (full),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.ena_in   = 1'b1;
    bus.datos_in = d;
    step();
    bus.ena_in   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [$];
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.datos_in = '0;
    bus.ena_in   = 1'b0;
    bus.relu_on  = 1'b0;
    bus.ready_in = 1'b0;
    step();
    step();

    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_dout", 32'(bus.datos_out), 0);
    rst_n = 1'b1;
    step();

    // 1: basic order and latency
    push(8'h11);
    chk("t1_lat_valid", 32'(bus.valid_out), 1);
    chk("t1_lat_dout", 32'(bus.datos_out), 32'h11);
    push(8'h22);
    push(8'h33);
    chk("t1_count", 32'(count), 3);
    chk("t1_head", 32'(bus.datos_out), 32'h11);
    bus.ready_in = 1'b1;
    chk("t1_d0", 32'(bus.datos_out), 32'h11);
    step();
    chk("t1_d1", 32'(bus.datos_out), 32'h22);
    step();
    chk("t1_d2", 32'(bus.datos_out), 32'h33);
    chk("t1_v2", 32'(bus.valid_out), 1);
    step();
    chk("t1_empty", 32'(bus.valid_out), 0);
    chk("t1_dz", 32'(bus.datos_out), 0);
    bus.ready_in = 1'b0;

    // 2: ReLU sampled at push
    bus.relu_on = 1'b1;
    push(8'h85);
    push(8'h7F);
    push(8'h80);
    bus.relu_on = 1'b0;
    push(8'h85);
    bus.ready_in = 1'b1;
    chk("t2_r0", 32'(bus.datos_out), 32'h00);
    step();
    chk("t2_r1", 32'(bus.datos_out), 32'h7F);
    step();
    chk("t2_r2", 32'(bus.datos_out), 32'h00);
    step();
    chk("t2_r3", 32'(bus.datos_out), 32'h85);
    step();
    chk("t2_empty", 32'(bus.valid_out), 0);
    bus.ready_in = 1'b0;

    // 3: overflow drops
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("t3_full", 32'(full), 1);
    chk("t3_cnt8", 32'(count), 8);
    chk("t3_ovf0", 32'(overflow), 0);
    push(8'h09);
    push(8'h0A);
    chk("t3_full2", 32'(full), 1);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_cnt), 2);
    chk("t3_cnt", 32'(count), 8);
    bus.ready_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain", 32'(bus.datos_out), 32'(i));
      step();
    end
    chk("t3_empty", 32'(bus.valid_out), 0);
    chk("t3_sticky", 32'(overflow), 1);
    bus.ready_in = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_clr_drop", 32'(drop_cnt), 0);

    // 4: push+pop while full
    for (int i = 1; i <= 8; i++) push(8'(i));
    bus.ready_in = 1'b1;
    push(8'h55);
    chk("t4_cnt", 32'(count), 8);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_drop", 32'(drop_cnt), 0);
    for (int i = 2; i <= 8; i++) begin
      chk("t4_drain", 32'(bus.datos_out), 32'(i));
      step();
    end
    chk("t4_last", 32'(bus.datos_out), 32'h55);
    step();
    chk("t4_empty", 32'(bus.valid_out), 0);
    bus.ready_in = 1'b0;

    // 5: clear beats push
    push(8'h01);
    push(8'h02);
    push(8'h03);
    clear        = 1'b1;
    bus.ena_in   = 1'b1;
    bus.datos_in = 8'h99;
    step();
    clear      = 1'b0;
    bus.ena_in = 1'b0;
    chk("t5_cnt", 32'(count), 0);
    chk("t5_valid", 32'(bus.valid_out), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_drop", 32'(drop_cnt), 0);
    chk("t5_dout", 32'(bus.datos_out), 0);
    push(8'h42);
    chk("t5_after", 32'(bus.datos_out), 32'h42);
    chk("t5_cnt1", 32'(count), 1);
    bus.ready_in = 1'b1;
    step();
    bus.ready_in = 1'b0;
    chk("t5_empty", 32'(bus.valid_out), 0);

    // 6: async reset mid-cycle, then wrap
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    chk("t6_cnt5", 32'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rcnt", 32'(count), 0);
    chk("t6_rvalid", 32'(bus.valid_out), 0);
    chk("t6_rdout", 32'(bus.datos_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push(8'hAA);
    chk("t6_aa", 32'(bus.datos_out), 32'hAA);
    chk("t6_cnt1", 32'(count), 1);
    exp_q.push_back(8'hAA);
    bus.ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'(8'h30 + 3 * i);
      exp_q.push_back(d);
      void'(exp_q.pop_front());
      push(d);
      chk("t6_wrap", 32'(bus.datos_out), 32'(exp_q[0]));
      chk("t6_wcnt", 32'(count), 1);
    end
    step();
    chk("t6_end", 32'(bus.valid_out), 0);
    bus.ready_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
